// File: rtl/corescore_led_pkg.sv
// Shared mode constants, FSM state type and sizing helper for the LED activity driver.
package corescore_led_pkg;

    localparam logic [1:0] LED_MODE_OFF       = 2'd0;
    localparam logic [1:0] LED_MODE_STRETCH   = 2'd1;
    localparam logic [1:0] LED_MODE_DIRECT    = 2'd2;
    localparam logic [1:0] LED_MODE_HEARTBEAT = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } led_state_t;

    // Counter width able to hold n-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/corescore_led_stretch.sv
// One channel's pulse stretcher: IDLE/HOLD FSM with a retriggerable hold counter.
module corescore_led_stretch
    import corescore_led_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic act_evt,
    input  logic enable,
    output logic busy
);

    localparam int unsigned      CW     = cnt_w(HOLD_CYCLES);
    localparam logic [CW-1:0]    RELOAD = CW'(HOLD_CYCLES - 1);

    led_state_t      state;
    logic [CW-1:0]   cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (!enable) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            busy <= (state == HOLD);
            unique case (state)
                IDLE: if (act_evt) begin
                    state <= HOLD;
                    cnt   <= RELOAD;
                end
                HOLD: begin
                    if (act_evt)
                        cnt <= RELOAD;
                    else if (cnt != '0)
                        cnt <= cnt - 1'b1;
                    else
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/corescore_led_activity.sv
// Multi-channel LED activity driver: stretch / direct / heartbeat lit source, gated by global PWM.
// Define CORESCORE_LED_SYNC_EN to put a 2-flop synchroniser in front of the activity inputs.
module corescore_led_activity
    import corescore_led_pkg::*;
#(
    parameter int unsigned CHANNELS    = 3,
    parameter int unsigned PWM_W       = 8,
    parameter int unsigned HOLD_CYCLES = 1000000,
    parameter int unsigned HB_CYCLES   = 8000000,
    parameter logic        ACT_IDLE    = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [CHANNELS-1:0] i_act,
    input  logic [PWM_W-1:0]    i_duty,
    input  logic [1:0]          i_mode,
    output logic [CHANNELS-1:0] o_busy,
    output logic [CHANNELS-1:0] o_pwm
);

    localparam logic [CHANNELS-1:0] IDLE_VEC = {CHANNELS{ACT_IDLE}};
    localparam int unsigned         HBW      = cnt_w(HB_CYCLES);
    localparam logic [HBW-1:0]      HB_LAST  = HBW'(HB_CYCLES - 1);

    logic [CHANNELS-1:0] act_in;
    logic [CHANNELS-1:0] act_q;
    logic [CHANNELS-1:0] evt;
    logic [CHANNELS-1:0] lit;
    logic [PWM_W-1:0]    pwm_cnt;
    logic [HBW-1:0]      hb_cnt;
    logic                hb_phase;

`ifdef CORESCORE_LED_SYNC_EN
    logic [1:0][CHANNELS-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sync_q <= {IDLE_VEC, IDLE_VEC};
        else          sync_q <= {sync_q[0], i_act};
    end

    assign act_in = sync_q[1];
`else
    assign act_in = i_act;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) act_q <= IDLE_VEC;
        else          act_q <= act_in;
    end

    assign evt = act_q ^ IDLE_VEC;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) pwm_cnt <= '0;
        else          pwm_cnt <= pwm_cnt + 1'b1;
    end

    // Heartbeat only runs while selected so every entry starts from a known phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hb_cnt   <= '0;
            hb_phase <= 1'b0;
        end else if (i_mode != LED_MODE_HEARTBEAT) begin
            hb_cnt   <= '0;
            hb_phase <= 1'b0;
        end else if (hb_cnt == HB_LAST) begin
            hb_cnt   <= '0;
            hb_phase <= ~hb_phase;
        end else begin
            hb_cnt   <= hb_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        corescore_led_stretch #(
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_stretch (
            .clk     (i_clk),
            .rst_n   (i_rst_n),
            .act_evt (evt[g]),
            .enable  (i_mode == LED_MODE_STRETCH),
            .busy    (o_busy[g])
        );
    end

    always_comb begin
        lit = '0;
        unique case (i_mode)
            LED_MODE_STRETCH:   lit = o_busy;
            LED_MODE_DIRECT:    lit = evt;
            LED_MODE_HEARTBEAT: lit = {CHANNELS{hb_phase}};
            default:            lit = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_pwm <= '0;
        else          o_pwm <= lit & {CHANNELS{pwm_cnt < i_duty}};
    end

endmodule

// File: tb/tb_corescore_led_activity.sv
// Randomised bench for corescore_led_activity against an edge-history reference model.
module tb_corescore_led_activity;

    localparam int CH   = 3;
    localparam int PW   = 4;
    localparam int HOLD = 10;
    localparam int HB   = 8;
    localparam logic IDLE_LVL = 1'b1;
`ifdef CORESCORE_LED_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif
    localparam int MAXE = 2048;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] act = '1;
    logic [PW-1:0] duty = '0;
    logic [1:0]    mode = 2'd0;
    logic [CH-1:0] o_busy, o_pwm;

    int n_tests = 0;
    int n_fail  = 0;
    int t = 0;

    logic [CH-1:0] act_h  [0:MAXE];
    logic [1:0]    mode_h [0:MAXE];
    logic [PW-1:0] duty_h [0:MAXE];

    corescore_led_activity #(
        .CHANNELS(CH), .PWM_W(PW), .HOLD_CYCLES(HOLD), .HB_CYCLES(HB), .ACT_IDLE(IDLE_LVL)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_act(act), .i_duty(duty), .i_mode(mode),
        .o_busy(o_busy), .o_pwm(o_pwm)
    );

    always #5 clk = ~clk;

    // Edge t samples act/mode/duty; outputs are observed 1 time unit later.
    task automatic tick();
        @(posedge clk);
        t++;
        act_h[t]  = act;
        mode_h[t] = mode;
        duty_h[t] = duty;
        #1;
    endtask

    // Busy after edge tt: some activity sample s lies LAT..LAT+HOLD-1 edges back and
    // STRETCH mode was selected at every edge from its first use onward.
    function automatic logic exp_busy(int ch, int tt);
        logic r = 1'b0;
        for (int s = tt - LAT - HOLD + 1; s <= tt - LAT; s++) begin
            if (s >= 1 && act_h[s][ch] != IDLE_LVL) begin
                logic ok = 1'b1;
                for (int e = s + LAT - 1; e <= tt; e++)
                    if (mode_h[e] != 2'd1) ok = 1'b0;
                if (ok) r = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic exp_evt(int ch, int tt);
        int s = tt - LAT + 1;
        if (s < 1) return 1'b0;
        return act_h[s][ch] != IDLE_LVL;
    endfunction

    // Phase = parity of completed HB-length runs within the current unbroken heartbeat stretch.
    function automatic logic exp_phase(int tt);
        int k = 0;
        int e = tt - 1;
        while (e >= 1 && mode_h[e] == 2'd3) begin
            k++;
            e--;
        end
        return ((k / HB) % 2) == 1;
    endfunction

    function automatic logic [CH-1:0] m_busy(int tt);
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = (tt >= 1) ? exp_busy(c, tt) : 1'b0;
        return v;
    endfunction

    function automatic logic [CH-1:0] m_pwm(int tt);
        logic [CH-1:0] v = '0;
        if (tt < 1) return v;
        for (int c = 0; c < CH; c++) begin
            logic l;
            case (mode_h[tt])
                2'd1:    l = (tt >= 2) ? exp_busy(c, tt - 1) : 1'b0;
                2'd2:    l = exp_evt(c, tt);
                2'd3:    l = exp_phase(tt);
                default: l = 1'b0;
            endcase
            v[c] = l && (((tt - 1) % (1 << PW)) < int'(duty_h[tt]));
        end
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        act = '1; mode = 2'd1; duty = 4'd15;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (o_busy !== 3'b000 || o_pwm !== 3'b000) begin
            n_fail++;
            $display("FAIL reset busy=%b pwm=%b want 000/000", o_busy, o_pwm);
        end
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
    endtask

    task automatic test_stretch_single();
        int ev_t, rise_t, hi_cnt;
        logic [CH-1:0] eb, ep;
        mode = 2'd1; duty = 4'($urandom_range(1, 15)); act = '1;
        tick();
        act = 3'b110;
        tick();
        ev_t = t; act = '1;
        rise_t = -1; hi_cnt = 0;
        for (int i = 0; i < HOLD + LAT + 8; i++) begin
            tick();
            eb = m_busy(t); ep = m_pwm(t);
            n_tests++;
            if (o_busy !== eb || o_pwm !== ep) begin
                n_fail++;
                $display("FAIL stretch_single t=%0d busy=%b want %b pwm=%b want %b", t, o_busy, eb, o_pwm, ep);
            end
            if (o_busy[0]) begin
                hi_cnt++;
                if (rise_t < 0) rise_t = t;
            end
        end
        n_tests++;
        if (rise_t != ev_t + LAT || hi_cnt != HOLD) begin
            n_fail++;
            $display("FAIL stretch_len rise=%0d want %0d len=%0d want %0d", rise_t, ev_t + LAT, hi_cnt, HOLD);
        end
    endtask

    task automatic test_retrigger();
        int last_ev, fall_t, gaps;
        logic seen, prev;
        logic [CH-1:0] eb, ep;
        mode = 2'd1; duty = 4'($urandom_range(0, 15));
        last_ev = 0; fall_t = -1; gaps = 0; seen = 1'b0; prev = 1'b0;
        for (int i = 0; i < 40 + HOLD + LAT + 6; i++) begin
            act = (i < 40 && i % 5 == 0) ? 3'b101 : 3'b111;
            tick();
            if (act[1] == 1'b0) last_ev = t;
            eb = m_busy(t); ep = m_pwm(t);
            n_tests++;
            if (o_busy !== eb || o_pwm !== ep) begin
                n_fail++;
                $display("FAIL retrigger t=%0d busy=%b want %b pwm=%b want %b", t, o_busy, eb, o_pwm, ep);
            end
            if (o_busy[1]) seen = 1'b1;
            if (prev && !o_busy[1]) begin
                if (fall_t < 0) fall_t = t;
                else gaps++;
            end
            prev = o_busy[1];
        end
        act = '1;
        n_tests++;
        if (!seen || gaps != 0 || fall_t != last_ev + LAT + HOLD) begin
            n_fail++;
            $display("FAIL retrigger_fall fall=%0d want %0d gaps=%0d", fall_t, last_ev + LAT + HOLD, gaps);
        end
    endtask

    task automatic test_direct_pwm();
        logic [PW-1:0] duties [3] = '{4'd4, 4'd0, 4'd15};
        logic [CH-1:0] eb, ep;
        int hi;
        mode = 2'd2; act = 3'b000;
        for (int d = 0; d < 3; d++) begin
            duty = duties[d];
            repeat (LAT + 1) tick();
            hi = 0;
            for (int i = 0; i < 16; i++) begin
                tick();
                eb = m_busy(t); ep = m_pwm(t);
                n_tests++;
                if (o_busy !== eb || o_pwm !== ep) begin
                    n_fail++;
                    $display("FAIL direct t=%0d busy=%b want %b pwm=%b want %b", t, o_busy, eb, o_pwm, ep);
                end
                if (o_pwm[2]) hi++;
            end
            n_tests++;
            if (hi != int'(duty)) begin
                n_fail++;
                $display("FAIL direct_duty duty=%0d high=%0d want %0d", duty, hi, duty);
            end
        end
        act = '1;
    endtask

    task automatic test_heartbeat();
        logic [CH-1:0] eb, ep;
        mode = 2'd3; duty = 4'd15;
        for (int i = 0; i < 5 * HB; i++) begin
            act = CH'($urandom);
            tick();
            eb = m_busy(t); ep = m_pwm(t);
            n_tests++;
            if (o_busy !== eb || o_pwm !== ep) begin
                n_fail++;
                $display("FAIL heartbeat t=%0d busy=%b want %b pwm=%b want %b", t, o_busy, eb, o_pwm, ep);
            end
        end
        mode = 2'd0;
        tick();
        n_tests++;
        if (o_pwm !== 3'b000 || o_busy !== 3'b000) begin
            n_fail++;
            $display("FAIL hb_to_off pwm=%b busy=%b want 000/000", o_pwm, o_busy);
        end
        act = '1;
    endtask

    task automatic test_random();
        logic [CH-1:0] eb, ep, a;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 9) == 0) duty = PW'($urandom);
            for (int c = 0; c < CH; c++) a[c] = ($urandom_range(0, 7) == 0) ? ~IDLE_LVL : IDLE_LVL;
            act = a;
            tick();
            eb = m_busy(t); ep = m_pwm(t);
            n_tests++;
            if (o_busy !== eb || o_pwm !== ep) begin
                n_fail++;
                $display("FAIL random t=%0d mode=%0d busy=%b want %b pwm=%b want %b", t, mode_h[t], o_busy, eb, o_pwm, ep);
            end
        end
        act = '1;
    endtask

    task automatic test_reset_mid_hold();
        logic [CH-1:0] eb, ep;
        mode = 2'd1; duty = 4'd15;
        act = 3'b000;
        tick();
        act = '1;
        repeat (LAT + 2) tick();
        n_tests++;
        if (o_busy !== 3'b111) begin
            n_fail++;
            $display("FAIL pre_reset_hold busy=%b want 111", o_busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (o_busy !== 3'b000 || o_pwm !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset busy=%b pwm=%b want 000/000", o_busy, o_pwm);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        for (int i = 0; i < HOLD + 6; i++) begin
            tick();
            eb = m_busy(t); ep = m_pwm(t);
            n_tests++;
            if (o_busy !== 3'b000 || o_pwm !== 3'b000 || eb !== 3'b000 || ep !== 3'b000) begin
                n_fail++;
                $display("FAIL post_reset t=%0d busy=%b pwm=%b want 000/000", t, o_busy, o_pwm);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stretch_single();
        test_retrigger();
        test_direct_pwm();
        test_heartbeat();
        test_random();
        test_reset_mid_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
